// File: rtl/dateset_pkg.sv
// dateset_pkg: shared types and helpers for the date-set encoder.
//   state_t     - encoder FSM states (fixed encodings for legacy compatibility)
//   FIELD_*     - edit_field output codes
//   month_len() - days in a month given the February length input;
//                 any feb_day other than 29 is treated as 28.
package dateset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EDIT_MONTH = 3'd1,
        ST_EDIT_DAY   = 3'd2,
        ST_COMPUTE    = 3'd3,
        ST_LOAD       = 3'd4
    } state_t;

    localparam logic [1:0] FIELD_IDLE  = 2'b00;
    localparam logic [1:0] FIELD_MONTH = 2'b01;
    localparam logic [1:0] FIELD_DAY   = 2'b10;
    localparam logic [1:0] FIELD_BUSY  = 2'b11;

    function automatic logic [7:0] month_len(input logic [7:0] month,
                                             input logic [7:0] feb_day);
        logic [7:0] feb;
        feb = (feb_day == 8'd29) ? 8'd29 : 8'd28;
        case (month)
            8'd2:                     month_len = feb;
            8'd4, 8'd6, 8'd9, 8'd11:  month_len = 8'd30;
            default:                  month_len = 8'd31;
        endcase
    endfunction

endpackage

// File: rtl/dateset_field_ctr.sv
// dateset_field_ctr: wrapping up/down counter over 1..bound.
//   clk, reset  - clock, synchronous active-high reset (value -> 1)
//   inc, dec    - step up / down; wraps bound->1 and 1->bound
//   clamp       - limit value to bound (takes priority over inc/dec)
//   load        - load load_val (highest priority)
//   bound       - dynamic upper limit
//   value       - current count
module dateset_field_ctr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clamp,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] bound,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= W'(1);
        end else if (load) begin
            value <= load_val;
        end else if (clamp) begin
            if (value > bound)
                value <= bound;
        end else if (inc) begin
            // >= so that a value left above a shrunken bound still wraps to 1
            value <= (value >= bound) ? W'(1) : value + W'(1);
        end else if (dec) begin
            value <= (value <= W'(1)) ? bound : value - W'(1);
        end
    end

endmodule

// File: rtl/dateset_encoder.sv
// dateset_encoder: month/day entry via button pulses, converted to a
// 1-based day-of-year count that presets the shared day counter.
//   clk, reset          - clock, synchronous active-high reset
//   btn_mode            - start / advance field / commit pulse
//   btn_inc, btn_dec    - increment / decrement current field pulses
//   feb_day             - February length (29, else treated as 28)
//   month_set, day_set  - field values being edited / last committed
//   edit_field          - 00 idle, 01 month, 10 day, 11 computing/loading
//   busy                - high while computing or loading
//   doy_out, doy_load   - day-of-year result and its one-cycle strobe
// Optional: define DATESET_TIMEOUT_EN to abandon an edit after TIMEOUT_CYC
// button-free cycles, restoring the last committed month/day.
module dateset_encoder
    import dateset_pkg::*;
#(
    parameter int unsigned MAX_MONTH   = 4,
    parameter int unsigned DOY_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic [7:0]       feb_day,
    output logic [7:0]       month_set,
    output logic [7:0]       day_set,
    output logic [1:0]       edit_field,
    output logic             busy,
    output logic [DOY_W-1:0] doy_out,
    output logic             doy_load
);

    state_t           state;
    logic [7:0]       idx;
    logic [DOY_W-1:0] acc;
    logic [7:0]       day_bound;
    logic [7:0]       idx_len;
    logic [7:0]       day_eff;
    logic             inc_ok;
    logic             dec_ok;
    logic             month_en;
    logic             day_en;
    logic             day_clamp;
    logic             restore;
    logic [7:0]       restore_month;
    logic [7:0]       restore_day;

    // Mode wins over inc/dec; inc and dec together cancel.
    assign inc_ok   = btn_inc & ~btn_dec & ~btn_mode;
    assign dec_ok   = btn_dec & ~btn_inc & ~btn_mode;
    assign month_en = (state == ST_EDIT_MONTH);
    assign day_en   = (state == ST_EDIT_DAY);

    assign day_bound = month_len(month_set, feb_day);
    assign idx_len   = month_len(idx, feb_day);

    // Day is clamped on entry to day editing and again on the first
    // compute cycle, so a feb_day change after editing is honoured.
    assign day_clamp = (month_en & btn_mode) |
                       ((state == ST_COMPUTE) && (idx == 8'd1));

    // The first compute cycle may also be the last (January), so the
    // clamped day is formed here rather than waiting for the register.
    always_comb begin
        day_eff = day_set;
        if ((idx == 8'd1) && (day_set > day_bound))
            day_eff = day_bound;
    end

`ifdef DATESET_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic [7:0]  commit_month;
    logic [7:0]  commit_day;
    logic        any_btn;

    assign any_btn = btn_mode | btn_inc | btn_dec;
    assign restore = (month_en | day_en) & ~any_btn &
                     (idle_cnt == 32'(TIMEOUT_CYC - 1));
    assign restore_month = commit_month;
    assign restore_day   = commit_day;

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt     <= '0;
            commit_month <= 8'd1;
            commit_day   <= 8'd1;
        end else begin
            if (state == ST_LOAD) begin
                commit_month <= month_set;
                commit_day   <= day_set;
            end
            if ((state == ST_IDLE) || any_btn || restore)
                idle_cnt <= '0;
            else if (month_en | day_en)
                idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    assign restore       = 1'b0;
    assign restore_month = 8'd1;
    assign restore_day   = 8'd1;
`endif

    dateset_field_ctr #(.W(8)) u_month (
        .clk      (clk),
        .reset    (reset),
        .inc      (month_en & inc_ok),
        .dec      (month_en & dec_ok),
        .clamp    (1'b0),
        .load     (restore),
        .load_val (restore_month),
        .bound    (8'(MAX_MONTH)),
        .value    (month_set)
    );

    dateset_field_ctr #(.W(8)) u_day (
        .clk      (clk),
        .reset    (reset),
        .inc      (day_en & inc_ok),
        .dec      (day_en & dec_ok),
        .clamp    (day_clamp),
        .load     (restore),
        .load_val (restore_day),
        .bound    (day_bound),
        .value    (day_set)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc     <= '0;
            idx     <= 8'd1;
            doy_out <= DOY_W'(1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_mode)
                        state <= ST_EDIT_MONTH;
                end
                ST_EDIT_MONTH: begin
                    if (restore)
                        state <= ST_IDLE;
                    else if (btn_mode)
                        state <= ST_EDIT_DAY;
                end
                ST_EDIT_DAY: begin
                    if (restore) begin
                        state <= ST_IDLE;
                    end else if (btn_mode) begin
                        state <= ST_COMPUTE;
                        acc   <= '0;
                        idx   <= 8'd1;
                    end
                end
                ST_COMPUTE: begin
                    if (idx < month_set) begin
                        acc <= acc + DOY_W'(idx_len);
                        idx <= idx + 8'd1;
                    end else begin
                        doy_out <= acc + DOY_W'(day_eff);
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_IDLE:       edit_field = FIELD_IDLE;
            ST_EDIT_MONTH: edit_field = FIELD_MONTH;
            ST_EDIT_DAY:   edit_field = FIELD_DAY;
            default:       edit_field = FIELD_BUSY;
        endcase
    end

    assign busy     = (state == ST_COMPUTE) || (state == ST_LOAD);
    assign doy_load = (state == ST_LOAD);

endmodule

// File: tb/tb_dateset_encoder.sv
module tb_dateset_encoder;

    localparam int unsigned MAXM = 4;
    localparam int unsigned DW   = 8;
`ifdef DATESET_TIMEOUT_EN
    localparam int unsigned TOC  = 16;
`else
    localparam int unsigned TOC  = 50_000_000;
`endif

    logic          clk, reset, btn_mode, btn_inc, btn_dec;
    logic [7:0]    feb_day, month_set, day_set;
    logic [1:0]    edit_field;
    logic          busy, doy_load;
    logic [DW-1:0] doy_out;

    dateset_encoder #(.MAX_MONTH(MAXM), .DOY_W(DW), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .feb_day(feb_day), .month_set(month_set),
        .day_set(day_set), .edit_field(edit_field), .busy(busy),
        .doy_out(doy_out), .doy_load(doy_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int doy; int mon; int day; int at; } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: calendar arithmetic plus the user-visible edit flow.
    int m = 1, d = 1, cm = 1, cd = 1, phase = 0, idle = 0, rem = 0;
    int force_exp = -1;

    function automatic int mlen(input int mo, input int fb);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2) return (fb == 29) ? 29 : 28;
        return t[mo-1];
    endfunction

    function automatic int doy_of(input int mo, input int dy, input int fb);
        int s = dy;
        for (int i = 1; i < mo; i++) s += mlen(i, fb);
        return s;
    endfunction

    task automatic step(input bit bm, input bit bi, input bit bd);
        exp_t e;
        int lim;
        btn_mode = bm; btn_inc = bi; btn_dec = bd;
        @(posedge clk);
        #1;
        btn_mode = 0; btn_inc = 0; btn_dec = 0;
        case (phase)
            0: if (bm) begin phase = 1; idle = 0; end
            1, 2: begin
                lim = (phase == 1) ? MAXM : mlen(m, feb_day);
                if (bm) begin
                    if (d > mlen(m, feb_day)) d = mlen(m, feb_day);
                    if (phase == 1) begin
                        phase = 2;
                    end else begin
                        e.doy = (force_exp >= 0) ? force_exp : doy_of(m, d, feb_day);
                        e.mon = m; e.day = d; e.at = cyc + m;
                        sbq.push_back(e);
                        force_exp = -1;
                        cm = m; cd = d;
                        phase = 3; rem = m;
                    end
                    idle = 0;
                end else begin
                    if (bi && !bd) begin
                        if (phase == 1) m = (m >= lim) ? 1 : m + 1;
                        else            d = (d >= lim) ? 1 : d + 1;
                    end else if (bd && !bi) begin
                        if (phase == 1) m = (m <= 1) ? lim : m - 1;
                        else            d = (d <= 1) ? lim : d - 1;
                    end
`ifdef DATESET_TIMEOUT_EN
                    if (bi || bd) idle = 0;
                    else begin
                        idle++;
                        if (idle == TOC) begin phase = 0; m = cm; d = cd; end
                    end
`endif
                end
            end
            default: if (rem == 0) phase = 0; else rem--;
        endcase
        @(negedge clk);
        chk("month_set", int'(month_set), m);
        chk("day_set", int'(day_set), d);
        chk("edit_field", int'(edit_field), (phase == 3) ? 3 : phase);
        chk("busy", int'(busy), (phase == 3) ? 1 : 0);
    endtask

    task automatic settle();
        int n = rem + 1;
        repeat (n) step(1'b0, 1'($urandom & 1), 1'($urandom & 1));
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        sbq.delete();
        m = 1; d = 1; cm = 1; cd = 1; phase = 0; idle = 0; rem = 0;
        @(negedge clk);
        chk("rst_month", int'(month_set), 1);
        chk("rst_day", int'(day_set), 1);
        chk("rst_doy", int'(doy_out), 1);
        chk("rst_load", int'(doy_load), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_field", int'(edit_field), 0);
    endtask

    // Monitor: every strobe must match the oldest outstanding commit.
    always @(negedge clk) begin
        if (!reset && doy_load) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got doy_load=1 with doy_out=%0d, required no strobe", doy_out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("doy_out", int'(doy_out), e.doy);
                chk("strobe_cycle", cyc, e.at);
                chk("commit_month", int'(month_set), e.mon);
                chk("commit_day", int'(day_set), e.day);
            end
        end
    end

    initial begin
        int fl[5] = '{28, 29, 0, 30, 200};
        int r;
        btn_mode = 0; btn_inc = 0; btn_dec = 0; feb_day = 8'd28; reset = 1;
        @(negedge clk);
        do_reset();

        // No edits: Jan 1 after two cycles
        step(1, 0, 0); step(1, 0, 0);
        force_exp = 1; step(1, 0, 0); settle();

        // Mar 5 with feb 28 -> 64
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 0); step(1, 0, 0);
        repeat (4) step(0, 1, 0);
        force_exp = 64; step(1, 0, 0); settle();

        // same entry with leap February -> 65
        feb_day = 8'd29;
        step(1, 0, 0); step(1, 0, 0);
        force_exp = 65; step(1, 0, 0); settle();

        // Apr 30, feb 29 -> 121; day dec from 1 wraps to 30
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0);
        repeat (4) step(0, 0, 1);
        chk("day_at_1", int'(day_set), 1);
        step(0, 0, 1);
        chk("day_wrap", int'(day_set), 30);
        force_exp = 121; step(1, 0, 0); settle();

        // month wrap both directions, then Jan 31
        step(1, 0, 0); step(0, 1, 0);
        chk("month_inc_wrap", int'(month_set), 1);
        step(0, 0, 1);
        chk("month_dec_wrap", int'(month_set), 4);
        step(0, 1, 0); step(1, 0, 0); step(0, 0, 1); step(0, 1, 0); step(0, 1, 0);
        chk("jan31", int'(day_set), 31);
        force_exp = 31; step(1, 0, 0); settle();

        // back to February with feb 28: day clamps on entry
        feb_day = 8'd28;
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0);
        chk("clamp_feb", int'(day_set), 28);
        force_exp = 59; step(1, 0, 0); settle();

        // inc+dec ignored; mode+inc advances without editing
        step(1, 0, 0); step(0, 1, 1);
        chk("incdec_month", int'(month_set), 2);
        step(1, 1, 0);
        chk("modeinc_field", int'(edit_field), 2);
        chk("modeinc_month", int'(month_set), 2);
        step(0, 1, 1);
        chk("incdec_day", int'(day_set), 28);
        step(1, 0, 0); settle();

        // reset mid-compute aborts without a strobe
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 0); step(1, 0, 0); step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0);
        do_reset();
        repeat (8) step(0, 0, 0);

`ifdef DATESET_TIMEOUT_EN
        // commit Feb 3, then abandon an Mar 4 edit
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0); step(0, 1, 0);
        force_exp = 34; step(1, 0, 0); settle();
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
        repeat (15) step(0, 0, 0);
        chk("to_still_edit", int'(edit_field), 2);
        step(0, 0, 0);
        chk("to_field", int'(edit_field), 0);
        chk("to_month", int'(month_set), 2);
        chk("to_day", int'(day_set), 3);
        repeat (4) step(0, 0, 0);
`endif

        // randomized entries
        repeat (40) begin
            feb_day = 8'(fl[$urandom_range(0, 4)]);
            repeat ($urandom_range(0, 2)) step(0, 1'($urandom & 1), 1'($urandom & 1));
            step(1, 0, 0);
            for (int f = 0; f < 2; f++) begin
                for (int k = 0; k < 8; k++) begin
                    r = $urandom_range(0, 7);
                    if (r == 7) break;
                    step(0, (r <= 2) || (r == 5), ((r == 3) || (r == 4) || (r == 5)));
                end
                if (f == 0) step(1, 1'($urandom & 1), 1'($urandom & 1));
            end
            step(1, 0, 0);
            settle();
        end

        repeat (3) step(0, 0, 0);
        chk("pending_commits", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dateset_encoder.md
Name: dateset_encoder

Overview:
- Inverse of the day-counter-to-month/day display path: the user enters a month and day with button pulses, and the block converts them into a day-of-year count.
- The result is loaded into the shared day counter (the cntr99 source) so the calendar can be preset.
- Sits between debounced button pulses / switches and the day counter; month_set/day_set drive the seven-segment display while editing.

Parameters:
- MAX_MONTH, 4, highest selectable month (1..12); months wrap MAX_MONTH->1.
- DOY_W, 8, width of day-of-year output; must hold the sum of month lengths up to MAX_MONTH.
- TIMEOUT_CYC, 50_000_000, idle-cycle limit, used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_mode  input  1  single-cycle pulse: start / advance field / commit.
- btn_inc  input  1  single-cycle pulse: increment current field.
- btn_dec  input  1  single-cycle pulse: decrement current field.
- feb_day  input  8  February length (28 or 29); any other value is treated as 28.
- month_set  output  8  month being edited / last committed, 1..MAX_MONTH.
- day_set  output  8  day being edited / last committed, 1..month length.
- edit_field  output  2  00 idle, 01 month, 10 day, 11 computing/loading.
- busy  output  1  high in COMPUTE and LOAD.
- doy_out  output  DOY_W  day-of-year result, 1-based (Jan 1 = 1).
- doy_load  output  1  one-cycle strobe; doy_out is valid in that cycle and held afterwards.

Behaviour:
- Reset (sync, high): state IDLE, month_set=1, day_set=1, doy_out=1, doy_load=0, busy=0, edit_field=00, accumulators cleared.
- Reset mid-edit or mid-compute aborts immediately; no doy_load is issued.
- States:
  - IDLE: btn_mode -> EDIT_MONTH.
  - EDIT_MONTH: btn_mode -> EDIT_DAY.
  - EDIT_DAY: btn_mode -> COMPUTE.
  - COMPUTE: runs to completion -> LOAD.
  - LOAD: -> IDLE after 1 cycle.
- Month length table: 31, feb_day, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31.
- EDIT_MONTH: inc wraps MAX_MONTH->1; dec wraps 1->MAX_MONTH.
- Entering EDIT_DAY clamps day_set to the current month length.
- EDIT_DAY: inc wraps len->1; dec wraps 1->len, where len uses the current feb_day.
- Button priority in a cycle: btn_mode wins and inc/dec are ignored; inc and dec together are ignored; all buttons are ignored in IDLE (except mode), COMPUTE and LOAD.
- COMPUTE is iterative: acc=0, idx=1. Each cycle:
  - if idx<month_set: acc+=len(idx), idx++;
  - else: doy_out<=acc+day_set, go to LOAD.
- COMPUTE takes exactly month_set cycles. Before the first accumulate, day_set is re-clamped against the current feb_day.
- Latency: btn_mode in EDIT_DAY at cycle t -> doy_load high at cycle t+1+month_set.
- Arithmetic is unsigned, DOY_W wide; overflow is impossible by parameter constraint.
- feb_day is sampled every COMPUTE cycle; a change mid-compute is permitted and the result is defined by the values sampled.

Optional Feature:
- Macro DATESET_TIMEOUT_EN.
- When defined: a counter clears on any button pulse and on leaving IDLE. If TIMEOUT_CYC consecutive cycles pass without a button while in EDIT_MONTH or EDIT_DAY, the block returns to IDLE with no doy_load. month_set/day_set revert to the last committed values (1/1 after reset).
- When undefined: editing persists indefinitely; no counter logic exists.

Decomposition:
- Package dateset_pkg:
  - state enum (IDLE, EDIT_MONTH, EDIT_DAY, COMPUTE, LOAD);
  - edit_field codes;
  - function month_len(month, feb_day) returning 8 bits with the feb_day sanitising rule.
- One sub-module, dateset_field_ctr: a wrapping up/down counter with a dynamic upper bound and clamp input. Instantiated twice, for month and day.

Test Plan:
- Reset, then mode, mode, mode with no edits -> doy_load at t+2 with doy_out=1, month_set=1, day_set=1.
- Month inc x2 (->3), day inc x4 (->5), feb_day=28, commit -> doy_load at t+4, doy_out=64.
- Same entry with feb_day=29 -> doy_out=65. With month=4, day=30, feb_day=29 -> 121.
- Wrap and clamp:
  - month dec from 1 -> MAX_MONTH(4);
  - day dec from 1 -> 30;
  - set month 1, day 31, go back to month 2 with feb 28 -> entering EDIT_DAY shows day_set=28.
- Simultaneous inc+dec -> field unchanged; mode+inc -> field advances, value unchanged. Assert reset during COMPUTE -> no doy_load, outputs at reset values next cycle.
- With DATESET_TIMEOUT_EN and TIMEOUT_CYC=16: enter EDIT_DAY, no buttons for 16 cycles -> IDLE, no strobe, month_set/day_set restored to the last committed values.
